// File: rtl/serial_divider_pkg.sv
// ============================================================================
// Module   : serial_divider_pkg
// Brief    : Shared FSM state encoding, register offsets and bit indices
//            for the serial divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_divider_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_CALC = 2'd2,
        S_FIX  = 2'd3
    } div_state_t;

    // Word index taken from byte-address bits [4:2]
    localparam logic [2:0] c_reg_dividend  = 3'd0;
    localparam logic [2:0] c_reg_divisor   = 3'd1;
    localparam logic [2:0] c_reg_ctrl      = 3'd2;
    localparam logic [2:0] c_reg_status    = 3'd3;
    localparam logic [2:0] c_reg_quotient  = 3'd4;
    localparam logic [2:0] c_reg_remainder = 3'd5;

    localparam int c_ctrl_start  = 0;
    localparam int c_ctrl_signed = 1;
    localparam int c_ctrl_irq_en = 2;

    localparam int c_stat_busy = 0;
    localparam int c_stat_done = 1;
    localparam int c_stat_dbz  = 2;

endpackage

`default_nettype wire

// File: rtl/serial_divider_core.sv
// ============================================================================
// Module   : serial_divider_core
// Brief    : Restoring shift-subtract divider FSM, one quotient bit per cycle.
//            Signed operation is built only with SERIAL_DIVIDER_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_divider_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_signed,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_busy,
    output logic            o_fix,
    output logic            o_dbz,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder
);
    import serial_divider_pkg::*;

    localparam int c_cw = $clog2(XLEN);

    div_state_t      r_state;
    logic [c_cw-1:0] r_cnt;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dsr;
    logic            r_dbz;
    logic [XLEN-1:0] w_dvd_mag;
    logic [XLEN-1:0] w_dsr_mag;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;

    // Partial remainder stays below the divisor, so the top bit of the
    // difference is purely the borrow.
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_dsr};

`ifdef SERIAL_DIVIDER_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;
    logic w_neg_dvd;
    logic w_neg_dsr;

    assign w_neg_dvd   = i_signed & i_dividend[XLEN-1];
    assign w_neg_dsr   = i_signed & i_divisor[XLEN-1];
    assign w_dvd_mag   = w_neg_dvd ? -i_dividend : i_dividend;
    assign w_dsr_mag   = w_neg_dsr ? -i_divisor  : i_divisor;
    assign o_quotient  = r_dbz ? '1    : (r_neg_q ? -r_quo : r_quo);
    assign o_remainder = r_dbz ? r_rem : (r_neg_r ? -r_rem : r_rem);
`else
    logic w_unused_signed;

    assign w_unused_signed = i_signed;
    assign w_dvd_mag       = i_dividend;
    assign w_dsr_mag       = i_divisor;
    assign o_quotient      = r_dbz ? '1 : r_quo;
    assign o_remainder     = r_rem;
`endif

    assign o_busy = (r_state != S_IDLE);
    assign o_fix  = (r_state == S_FIX);
    assign o_dbz  = r_dbz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dsr   <= '0;
            r_dbz   <= 1'b0;
`ifdef SERIAL_DIVIDER_SIGNED_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) r_state <= S_PREP;
                end
                S_PREP: begin
                    r_cnt <= c_cw'(XLEN - 1);
                    r_quo <= w_dvd_mag;
                    r_dsr <= w_dsr_mag;
`ifdef SERIAL_DIVIDER_SIGNED_EN
                    r_neg_q <= w_neg_dvd ^ w_neg_dsr;
                    r_neg_r <= w_neg_dvd;
`endif
                    // Divide-by-zero skips CALC; remainder reports the raw dividend
                    if (i_divisor == '0) begin
                        r_dbz   <= 1'b1;
                        r_rem   <= i_dividend;
                        r_state <= S_FIX;
                    end else begin
                        r_dbz   <= 1'b0;
                        r_rem   <= '0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (w_diff[XLEN]) begin
                        r_rem <= w_shift[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], 1'b0};
                    end else begin
                        r_rem <= w_diff[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], 1'b1};
                    end
                    if (r_cnt == '0) r_state <= S_FIX;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/serial_divider_mc.sv
// ============================================================================
// Module   : serial_divider_mc
// Brief    : Wishbone-classic register front end and logic-analyser tap for
//            the serial divider. Macro SERIAL_DIVIDER_SIGNED_EN enables CTRL.signed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_divider_mc #(
    parameter int XLEN = 32,
    parameter int WBW  = 32
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [WBW/8-1:0]  wbs_sel_i,
    input  logic [WBW-1:0]    wbs_adr_i,
    input  logic [WBW-1:0]    wbs_dat_i,
    output logic [WBW-1:0]    wbs_dat_o,
    output logic              wbs_ack_o,
    output logic              start_o,
    output logic              fini_o,
    output logic              irq_o,
    output logic [4*XLEN-1:0] la_data_o
);
    import serial_divider_pkg::*;

    logic [XLEN-1:0] r_dividend;
    logic [XLEN-1:0] r_divisor;
    logic [XLEN-1:0] r_quotient;
    logic [XLEN-1:0] r_remainder;
    logic            r_irq_en;
    logic            r_done;
    logic            r_dbz;
    logic            w_signed;
    logic            w_req;
    logic            w_wr;
    logic            w_start;
    logic [2:0]      w_sel;
    logic [WBW-1:0]  w_rdata;
    logic            w_busy;
    logic            w_fix;
    logic            w_core_dbz;
    logic [XLEN-1:0] w_core_quo;
    logic [XLEN-1:0] w_core_rem;
    logic            w_unused;

    assign w_unused = ^{wbs_sel_i, wbs_adr_i[WBW-1:5], wbs_adr_i[1:0]};

    // Ack low in the request term keeps consecutive requests from acking back-to-back
    assign w_req   = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign w_wr    = w_req & wbs_we_i;
    assign w_sel   = wbs_adr_i[4:2];
    assign w_start = w_wr && (w_sel == c_reg_ctrl) && wbs_dat_i[c_ctrl_start] && !w_busy;

    assign irq_o     = r_done & r_irq_en;
    assign la_data_o = {r_dividend, r_divisor, r_quotient, r_remainder};

`ifdef SERIAL_DIVIDER_SIGNED_EN
    logic r_signed;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_signed <= 1'b0;
        end else if (w_wr && (w_sel == c_reg_ctrl) && !w_busy) begin
            r_signed <= wbs_dat_i[c_ctrl_signed];
        end
    end

    assign w_signed = r_signed;
`else
    assign w_signed = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            c_reg_dividend:  w_rdata[XLEN-1:0] = r_dividend;
            c_reg_divisor:   w_rdata[XLEN-1:0] = r_divisor;
            c_reg_ctrl: begin
                w_rdata[c_ctrl_signed] = w_signed;
                w_rdata[c_ctrl_irq_en] = r_irq_en;
            end
            c_reg_status: begin
                w_rdata[c_stat_busy] = w_busy;
                w_rdata[c_stat_done] = r_done;
                w_rdata[c_stat_dbz]  = r_dbz;
            end
            c_reg_quotient:  w_rdata[XLEN-1:0] = r_quotient;
            c_reg_remainder: w_rdata[XLEN-1:0] = r_remainder;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            start_o     <= 1'b0;
            fini_o      <= 1'b0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_irq_en    <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            wbs_ack_o <= w_req;
            wbs_dat_o <= (w_req && !wbs_we_i) ? w_rdata : '0;
            start_o   <= w_start;
            fini_o    <= w_fix;
            if (w_wr && !w_busy && (w_sel == c_reg_dividend)) r_dividend <= wbs_dat_i[XLEN-1:0];
            if (w_wr && !w_busy && (w_sel == c_reg_divisor))  r_divisor  <= wbs_dat_i[XLEN-1:0];
            if (w_wr && (w_sel == c_reg_ctrl)) r_irq_en <= wbs_dat_i[c_ctrl_irq_en];
            if (w_wr && (w_sel == c_reg_status)) begin
                if (wbs_dat_i[c_stat_done]) r_done <= 1'b0;
                if (wbs_dat_i[c_stat_dbz])  r_dbz  <= 1'b0;
            end
            if (w_start) begin
                r_done <= 1'b0;
                r_dbz  <= 1'b0;
            end
            // Placed last so a same-cycle W1C of done loses to the set
            if (w_fix) begin
                r_quotient  <= w_core_quo;
                r_remainder <= w_core_rem;
                r_done      <= 1'b1;
                r_dbz       <= w_core_dbz;
            end
        end
    end

    serial_divider_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk         (clk_i),
        .rst_n       (reset_ni),
        .i_start     (w_start),
        .i_signed    (w_signed),
        .i_dividend  (r_dividend),
        .i_divisor   (r_divisor),
        .o_busy      (w_busy),
        .o_fix       (w_fix),
        .o_dbz       (w_core_dbz),
        .o_quotient  (w_core_quo),
        .o_remainder (w_core_rem)
    );

endmodule

`default_nettype wire

// File: tb/tb_serial_divider_mc.sv
// ============================================================================
// Module   : tb_serial_divider_mc
// Brief    : Directed self-checking bench for serial_divider_mc.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_serial_divider_mc;

    localparam int XLEN = 32;
    localparam int WBW  = 32;

    logic               clk_i     = 1'b0;
    logic               reset_ni  = 1'b0;
    logic               wbs_stb_i = 1'b0;
    logic               wbs_cyc_i = 1'b0;
    logic               wbs_we_i  = 1'b0;
    logic [WBW/8-1:0]   wbs_sel_i = '1;
    logic [WBW-1:0]     wbs_adr_i = '0;
    logic [WBW-1:0]     wbs_dat_i = '0;
    logic [WBW-1:0]     wbs_dat_o;
    logic               wbs_ack_o;
    logic               start_o;
    logic               fini_o;
    logic               irq_o;
    logic [4*XLEN-1:0]  la_data_o;

    int cyc_cnt   = 0;
    int fini_cnt  = 0;
    int start_cnt = 0;
    int n_checks  = 0;
    int n_fail    = 0;

    serial_divider_mc #(.XLEN(XLEN), .WBW(WBW)) dut (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_dat_o (wbs_dat_o),
        .wbs_ack_o (wbs_ack_o),
        .start_o   (start_o),
        .fini_o    (fini_o),
        .irq_o     (irq_o),
        .la_data_o (la_data_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc_cnt++;

    always @(negedge clk_i) begin
        if (fini_o)  fini_cnt++;
        if (start_o) start_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        bit acked = 0;
        @(posedge clk_i); #1;
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 1; wbs_adr_i = a; wbs_dat_i = d;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i); #1;
            if (wbs_ack_o) begin acked = 1; break; end
        end
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
        if (!acked) check("wb_write_ack_timeout", 0, 1);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        bit acked = 0;
        d = 'x;
        @(posedge clk_i); #1;
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 0; wbs_adr_i = a;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i); #1;
            if (wbs_ack_o) begin acked = 1; d = wbs_dat_o; break; end
        end
        wbs_stb_i = 0; wbs_cyc_i = 0;
        if (!acked) check("wb_read_ack_timeout", 0, 1);
    endtask

    // Loads operands, writes CTRL, returns the cycle number in which start_o is high
    task automatic start_div(input logic [31:0] dvd, input logic [31:0] dsr,
                             input logic [31:0] ctrl, output int n);
        wb_write(32'h00, dvd);
        wb_write(32'h04, dsr);
        wb_write(32'h08, ctrl);
        n = cyc_cnt;
        check("start_pulse", start_o, 1'b1);
    endtask

    task automatic wait_fini(input int n, output int lat);
        bit seen = 0;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_i); #1;
            if (fini_o) begin seen = 1; break; end
        end
        if (seen) lat = cyc_cnt - n;
        else      check("fini_timeout", 0, 1);
    endtask

    task automatic run_div(input string tag, input logic [31:0] dvd, input logic [31:0] dsr,
                           input logic [31:0] ctrl, input int exp_lat,
                           input logic [31:0] exp_q, input logic [31:0] exp_r,
                           input logic [31:0] exp_status);
        int n, lat;
        logic [31:0] rd;
        start_div(dvd, dsr, ctrl, n);
        wait_fini(n, lat);
        check({tag, "_latency"}, lat, exp_lat);
        wb_read(32'h10, rd);
        check({tag, "_quotient"}, rd, exp_q);
        wb_read(32'h14, rd);
        check({tag, "_remainder"}, rd, exp_r);
        wb_read(32'h0C, rd);
        check({tag, "_status"}, rd, exp_status);
    endtask

    initial begin
        int n, lat, f0, s0;
        logic [31:0] rd;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ack",   wbs_ack_o, 1'b0);
        check("rst_start", start_o,   1'b0);
        check("rst_fini",  fini_o,    1'b0);
        check("rst_irq",   irq_o,     1'b0);
        check("rst_dat",   wbs_dat_o, 32'h0);
        check("rst_la",    la_data_o, 128'h0);
        reset_ni = 1;

        // Unsigned 100/7
        run_div("u100_7", 32'd100, 32'd7, 32'h1, 34, 32'd14, 32'd2, 32'h2);
        check("la_data", la_data_o, {32'd100, 32'd7, 32'd14, 32'd2});
        check("irq_disabled", irq_o, 1'b0);

        // -7/2 with signed requested
`ifdef SERIAL_DIVIDER_SIGNED_EN
        run_div("s_m7_2", 32'hFFFFFFF9, 32'd2, 32'h3, 34, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h2);
        wb_read(32'h08, rd);
        check("ctrl_signed_rb", rd, 32'h2);
`else
        run_div("s_m7_2", 32'hFFFFFFF9, 32'd2, 32'h3, 34, 32'h7FFFFFFC, 32'd1, 32'h2);
        wb_read(32'h08, rd);
        check("ctrl_signed_rb", rd, 32'h0);
`endif

        // Divide by zero with interrupt enabled, then W1C done
        run_div("dbz_5_0", 32'd5, 32'd0, 32'h5, 2, 32'hFFFFFFFF, 32'd5, 32'h6);
        check("dbz_irq_set", irq_o, 1'b1);
        wb_write(32'h0C, 32'h2);
        #1;
        check("dbz_irq_clr", irq_o, 1'b0);
        wb_read(32'h0C, rd);
        check("dbz_status_w1c", rd, 32'h4);

        // Most-negative / -1
`ifdef SERIAL_DIVIDER_SIGNED_EN
        run_div("s_ovf", 32'h80000000, 32'hFFFFFFFF, 32'h3, 34, 32'h80000000, 32'h0, 32'h2);
`else
        run_div("s_ovf", 32'h80000000, 32'hFFFFFFFF, 32'h3, 34, 32'h0, 32'h80000000, 32'h2);
`endif

        // Unmapped offset reads zero
        wb_write(32'h18, 32'hDEADBEEF);
        wb_read(32'h18, rd);
        check("unmapped_rd", rd, 32'h0);

        // Writes and a second start while busy are acked and ignored
        s0 = start_cnt;
        f0 = fini_cnt;
        start_div(32'd100, 32'd7, 32'h1, n);
        while (cyc_cnt < n + 4) @(posedge clk_i);
        wb_write(32'h04, 32'd3);
        wb_write(32'h08, 32'h1);
        wb_read(32'h0C, rd);
        check("busy_status", rd, 32'h1);
        wb_read(32'h04, rd);
        check("busy_divisor_kept", rd, 32'd7);
        wait_fini(n, lat);
        check("busy_latency", lat, 34);
        repeat (40) @(posedge clk_i);
        #1;
        check("busy_single_fini",  fini_cnt - f0,  1);
        check("busy_single_start", start_cnt - s0, 1);
        wb_read(32'h10, rd);
        check("busy_quotient", rd, 32'd14);
        wb_read(32'h14, rd);
        check("busy_remainder", rd, 32'd2);

        // Mid-operation reset aborts without fini_o
        start_div(32'd100, 32'd7, 32'h5, n);
        while (cyc_cnt < n + 10) @(posedge clk_i);
        #1;
        f0 = fini_cnt;
        reset_ni = 0;
        #1;
        check("mrst_ack",  wbs_ack_o, 1'b0);
        check("mrst_irq",  irq_o,     1'b0);
        check("mrst_dat",  wbs_dat_o, 32'h0);
        check("mrst_la",   la_data_o, 128'h0);
        repeat (2) @(posedge clk_i);
        #1;
        reset_ni = 1;
        repeat (40) @(posedge clk_i);
        #1;
        check("mrst_no_fini", fini_cnt - f0, 0);
        wb_read(32'h0C, rd);
        check("mrst_status", rd, 32'h0);
        run_div("post_rst_9_3", 32'd9, 32'd3, 32'h1, 34, 32'd3, 32'd0, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_divider_mc.md
SERIAL_DIVIDER_MC -- requirements
Module: serial_divider_mc

Interface
REQ-001 Parameter XLEN, default 32: operand and result width, and WBW (even, >=8).
REQ-002 Parameter WBW, default 32: Wishbone data width.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 reset_ni  in  1  asynchronous, active-low reset.
REQ-005 wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic slave strobe, cycle and write-enable.
REQ-006 wbs_sel_i  in  WBW/8  byte lanes; writes are full-word only, sel ignored.
REQ-007 wbs_adr_i  in  WBW  byte address; register select is bits [4:2].
REQ-008 wbs_dat_i  in  WBW  write data; wbs_dat_o  out  WBW  read data; wbs_ack_o  out  1  acknowledge.
REQ-009 start_o  out  1  one-cycle pulse when a division is accepted.
REQ-010 fini_o  out  1  one-cycle pulse when results become valid.
REQ-011 irq_o  out  1  level interrupt, STATUS.done AND CTRL.irq_en.
REQ-012 la_data_o  out  4*XLEN  {dividend, divisor, quotient, remainder}, MSB first.

Function
REQ-013 Register map: 0x00 DIVIDEND RW; 0x04 DIVISOR RW; 0x08 CTRL (bit0 start W1, reads 0; bit1 signed; bit2 irq_en); 0x0C STATUS (bit0 busy RO; bit1 done W1C; bit2 dbz W1C); 0x10 QUOTIENT RO; 0x14 REMAINDER RO; other offsets read 0, writes ignored.
REQ-014 wbs_ack_o asserts exactly one cycle after stb&cyc is sampled high with ack low, for one cycle; a new request is not acknowledged back-to-back.
REQ-015 FSM states IDLE, PREP, CALC, FIX.
REQ-016 IDLE->PREP on CTRL.start write while not busy; start_o pulses that cycle; done and dbz clear.
REQ-017 PREP (1 cycle): latch operand magnitudes and sign flags; divisor==0 -> FIX directly with dbz set.
REQ-018 CALC: restoring shift-subtract, one quotient bit per cycle, exactly XLEN cycles via down-counter.
REQ-019 FIX (1 cycle): apply signs (quotient negative iff signs differ; remainder takes dividend sign), write QUOTIENT/REMAINDER, set done, pulse fini_o, return IDLE.
REQ-020 Latency: start accepted at cycle N -> fini_o at N+XLEN+2; divide-by-zero -> N+2.
REQ-021 Divide-by-zero: quotient all ones, remainder = dividend, dbz=1.
REQ-022 Signed overflow (most-negative / -1): quotient = most-negative, remainder 0.
REQ-023 While busy: DIVIDEND/DIVISOR/CTRL.signed writes and start are ignored but acknowledged.
REQ-024 Bus W1C of done in the same cycle as FIX: set wins.

Reset
REQ-025 reset_ni low: FSM IDLE, all registers 0, wbs_ack_o/start_o/fini_o/irq_o 0, wbs_dat_o 0; a mid-operation reset aborts with no fini_o.

Configuration
REQ-026 Macro SERIAL_DIVIDER_SIGNED_EN defined: CTRL.signed honoured per REQ-019/022.
REQ-027 Macro undefined: CTRL.signed reads 0, writes ignored; all operations unsigned; sign logic not synthesised.

Structure
REQ-028 Package serial_divider_pkg holds the FSM state enum, register offset constants and CTRL/STATUS bit indices.
REQ-029 Sub-module serial_divider_core holds FSM, counter and datapath; the top holds the Wishbone register file and LA mapping.

Verification
REQ-030 Unsigned 100/7, XLEN=32: fini_o at N+34, QUOTIENT=14, REMAINDER=2, dbz=0.
REQ-031 Signed -7/2 (0xFFFFFFF9/2): QUOTIENT=0xFFFFFFFD, REMAINDER=0xFFFFFFFF; with macro undefined QUOTIENT=0x7FFFFFFC, REMAINDER=1.
REQ-032 5/0: fini_o at N+2, QUOTIENT=0xFFFFFFFF, REMAINDER=5, dbz=1; irq_o=1 when irq_en=1; W1C done -> irq_o=0.
REQ-033 Signed 0x80000000/0xFFFFFFFF: QUOTIENT=0x80000000, REMAINDER=0.
REQ-034 Start 100/7, write DIVISOR=3 and start again at N+5: ignored, acked, result 14 r 2, single fini_o.
REQ-035 reset_ni low at N+10: outputs 0, no fini_o; next 9/3 gives 3 r 0 at correct latency.
